// File: rtl/occ_multiphase_ton.sv
// rtl/occ_multiphase_ton.sv - multi-phase one-cycle-control ton calculator with a shared sequential divider
// Optional measured gap voltage: define OCC_MEASURED_VGAP_EN.
module occ_multiphase_ton #(
  parameter int NCH         = 2,
  parameter int CLK_PER_TS  = 400,
  parameter int VIN         = 120,
  parameter int L_NH        = 3300,
  parameter int FS_KHZ      = 250,
  parameter int V_GAP_FIXED = 20,
  parameter int IREF_MAX    = 50,
  parameter int TON_MAX     = 180,
  parameter int ERR_NEG     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NCH*16-1:0] sample_current,
  input  logic [15:0]       sample_voltage,
  input  logic [15:0]       i_set,
  output logic [NCH-1:0]    phase_start,
  output logic [NCH*16-1:0] ton,
  output logic [NCH-1:0]    ton_valid,
  output logic [NCH-1:0]    clamp_flag,
  output logic              overrun
);
  localparam int SLOT = CLK_PER_TS / NCH;
  localparam int CW   = $clog2(CLK_PER_TS);
  localparam int SH   = $clog2(NCH);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_PREP1 = 3'd2;
  localparam logic [2:0] S_PREP2 = 3'd3;
  localparam logic [2:0] S_DIV   = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;

  localparam logic signed [63:0] VIN_W = 64'(VIN);
  localparam logic signed [63:0] MEG   = 64'sd1000000;
  localparam logic signed [63:0] K_ERR = 64'(2) * 64'(VIN) * 64'(L_NH) * 64'(FS_KHZ);
  localparam logic signed [63:0] CLK_W = 64'(CLK_PER_TS);
  localparam logic signed [15:0] IREF_C = 16'(IREF_MAX);

  logic [CW-1:0]        count;
  logic [NCH-1:0]       slot_hit;
  logic                 any_hit, accept;
  logic [CHW-1:0]       hit_ch, ch;
  logic signed [15:0]   cur_sel, cur_r, iset_r, iset_sh, vg;
  logic signed [16:0]   id_r, iref_r, err_r, diff;
  logic signed [63:0]   vg_w;
  logic signed [47:0]   num48, n_sh;
  logic                 n_pos;
  logic [39:0]          d_r, rem;
  logic [40:0]          rem_sh;
  logic [47:0]          q;
  logic [5:0]           div_cnt;
  logic [2:0]           state;
  logic [15:0]          staged_ton [NCH];
  logic [NCH-1:0]       staged_valid, staged_clamp;

  always_comb begin
    slot_hit = '0;
    hit_ch   = '0;
    cur_sel  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (32'(count) == k * SLOT) begin
        slot_hit[k] = 1'b1;
        hit_ch      = CHW'(k);
        cur_sel     = sample_current[k*16 +: 16];
      end
    end
  end

  assign any_hit = |slot_hit;
  // WRITE finishes this cycle, so a slot start landing on it can still be taken.
  assign accept  = enable && any_hit && (state == S_IDLE || state == S_WRITE);
  assign iset_sh = iset_r >>> SH;
  assign diff    = iref_r - id_r;
  assign vg_w    = 64'(vg);
  assign num48   = 48'((vg_w * (VIN_W - vg_w) * MEG + K_ERR * 64'(err_r)) * CLK_W);
  assign rem_sh  = {rem, n_sh[47]};

`ifdef OCC_MEASURED_VGAP_EN
  localparam logic signed [15:0] VG_HI = 16'(VIN - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vg <= 16'(V_GAP_FIXED);
    else if (accept)
      vg <= sample_voltage;
    else if (state == S_LATCH)
      vg <= (vg < 16'sd1) ? 16'sd1 : ((vg > VG_HI) ? VG_HI : vg);
  end
`else
  logic unused_vgap;
  assign vg          = 16'(V_GAP_FIXED);
  assign unused_vgap = ^sample_voltage;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (!enable || 32'(count) == CLK_PER_TS - 1)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; ch <= '0; cur_r <= '0; iset_r <= '0;
      id_r <= '0; iref_r <= '0; err_r <= '0; n_sh <= '0; n_pos <= 1'b0;
      d_r <= '0; rem <= '0; q <= '0; div_cnt <= '0;
      staged_valid <= '0; staged_clamp <= '0;
      for (int k = 0; k < NCH; k++) staged_ton[k] <= '0;
    end else if (!enable) begin
      state <= S_IDLE; staged_valid <= '0; div_cnt <= '0;
    end else begin
      if (state == S_WRITE) begin
        staged_valid[ch] <= 1'b1;
        if (q > 48'(CLK_PER_TS)) begin
          staged_ton[ch] <= '0;              staged_clamp[ch] <= 1'b1;
        end else if (q > 48'(TON_MAX)) begin
          staged_ton[ch] <= 16'(TON_MAX);    staged_clamp[ch] <= 1'b1;
        end else begin
          staged_ton[ch] <= q[15:0];         staged_clamp[ch] <= 1'b0;
        end
      end
      if (accept) begin
        state <= S_LATCH; ch <= hit_ch; cur_r <= cur_sel; iset_r <= i_set;
      end else begin
        case (state)
          S_LATCH: begin
            id_r   <= (cur_r < 16'sd0) ? 17'sd0 : 17'(cur_r);
            iref_r <= (iset_sh > IREF_C) ? 17'(IREF_C) : 17'(iset_sh);
            state  <= S_PREP1;
          end
          S_PREP1: begin
            err_r <= (diff < 17'sd0) ? -17'(ERR_NEG) : diff;
            state <= S_PREP2;
          end
          S_PREP2: begin
            n_sh    <= num48;
            n_pos   <= num48 > 48'sd0;
            d_r     <= 40'(64'sd2 * VIN_W * (VIN_W - vg_w) * MEG);
            rem     <= '0;
            q       <= '0;
            div_cnt <= '0;
            state   <= S_DIV;
          end
          S_DIV: begin
            if (!n_pos) begin
              q     <= '0;
              state <= S_WRITE;
            end else begin
              if (rem_sh >= {1'b0, d_r}) begin
                rem <= 40'(rem_sh - {1'b0, d_r});
                q   <= {q[46:0], 1'b1};
              end else begin
                rem <= rem_sh[39:0];
                q   <= {q[46:0], 1'b0};
              end
              n_sh    <= n_sh <<< 1;
              div_cnt <= div_cnt + 6'd1;
              if (div_cnt == 6'd47) state <= S_WRITE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (enable && any_hit && !accept)
      overrun <= 1'b1;
  end

  // Commit reads the staged value from before this edge, which keeps ton fixed for the full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_start <= '0; ton <= '0; ton_valid <= '0; clamp_flag <= '0;
    end else if (!enable) begin
      phase_start <= '0; ton <= '0; ton_valid <= '0; clamp_flag <= '0;
    end else begin
      phase_start <= slot_hit;
      ton_valid   <= slot_hit & staged_valid;
      for (int k = 0; k < NCH; k++) begin
        if (slot_hit[k] && staged_valid[k]) begin
          ton[k*16 +: 16] <= staged_ton[k];
          clamp_flag[k]   <= staged_clamp[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_occ_multiphase_ton.sv
// tb/tb_occ_multiphase_ton.sv - randomized self-checking bench for occ_multiphase_ton
module tb_occ_multiphase_ton;
  localparam int NCH  = 2;
  localparam int CLKT = 400;
  localparam int SLOT = CLKT / NCH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic en2 = 1'b0;
  logic [31:0] sample_current = '0;
  logic [15:0] sample_voltage = '0;
  logic [15:0] i_set = '0;
  logic [1:0]  phase_start, ton_valid, clamp_flag;
  logic [31:0] ton;
  logic        overrun;
  logic [1:0]  ps_o, tv_o, cf_o;
  logic [31:0] ton_o;
  logic        overrun_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  occ_multiphase_ton dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sample_current(sample_current), .sample_voltage(sample_voltage), .i_set(i_set),
    .phase_start(phase_start), .ton(ton), .ton_valid(ton_valid),
    .clamp_flag(clamp_flag), .overrun(overrun)
  );

  occ_multiphase_ton #(.NCH(2), .CLK_PER_TS(100)) dut_short (
    .clk(clk), .rst_n(rst_n), .enable(en2),
    .sample_current(sample_current), .sample_voltage(sample_voltage), .i_set(i_set),
    .phase_start(ps_o), .ton(ton_o), .ton_valid(tv_o),
    .clamp_flag(cf_o), .overrun(overrun_o)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Quotient straight from the one-cycle-control equation, gap fixed at 20 V.
  function automatic longint model_q(input int id_raw, input int iset);
    int id, iref, err;
    longint n, d;
    id   = (id_raw < 0) ? 0 : id_raw;
    iref = iset / NCH;
    if (iref > 50) iref = 50;
    err  = iref - id;
    if (err < 0) err = -5;
    n = (64'sd20 * 64'sd100 * 64'sd1000000 + 64'sd2 * 120 * 3300 * 250 * err) * CLKT;
    d = 64'sd2 * 120 * 100 * 64'sd1000000;
    return (n <= 0) ? 0 : n / d;
  endfunction

  function automatic int ton_of(input longint q);
    return (q > CLKT) ? 0 : ((q > 180) ? 180 : int'(q));
  endfunction

  function automatic int clamp_of(input longint q);
    return (q > 180) ? 1 : 0;
  endfunction

  int  edge_n = 0;
  int  exp_ton [NCH];
  int  exp_clamp [NCH];
  int  pend_ton [NCH];
  int  pend_clamp [NCH];
  bit  pend_valid [NCH];

  always @(posedge clk) begin
    logic [1:0]  eps, etv, ecf;
    logic [31:0] eton;
    longint qv;
    #1;
    eps = '0; etv = '0;
    if (!rst_n || !enable) begin
      edge_n = 0;
      for (int k = 0; k < NCH; k++) begin
        exp_ton[k] = 0; exp_clamp[k] = 0; pend_valid[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (edge_n % CLKT == k * SLOT) begin
          eps[k] = 1'b1;
          if (pend_valid[k]) begin
            etv[k] = 1'b1;
            exp_ton[k] = pend_ton[k];
            exp_clamp[k] = pend_clamp[k];
          end
          qv = model_q(int'($signed(sample_current[k*16 +: 16])), int'(i_set));
          pend_ton[k] = ton_of(qv);
          pend_clamp[k] = clamp_of(qv);
          pend_valid[k] = 1'b1;
        end
      end
      edge_n++;
    end
    for (int k = 0; k < NCH; k++) begin
      eton[k*16 +: 16] = 16'(exp_ton[k]);
      ecf[k] = exp_clamp[k][0];
    end
    chk("phase_start", phase_start, eps);
    chk("ton_valid", ton_valid, etv);
    chk("ton", ton, eton);
    chk("clamp_flag", clamp_flag, ecf);
    chk("overrun_main", overrun, 0);
  end

  task automatic wait_ps(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (phase_start[k]) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_case(input int id0, input int id1, input int iset,
                          input int e0, input int e1, input int c0, input int c1);
    @(negedge clk);
    sample_current = {16'(id1), 16'(id0)};
    i_set = 16'(iset);
    repeat (2 * CLKT + 20) @(negedge clk);
    chk("case_ton0", ton[15:0], e0);
    chk("case_ton1", ton[31:16], e1);
    chk("case_clamp0", clamp_flag[0], c0);
    chk("case_clamp1", clamp_flag[1], c1);
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sample_current[15:0]  = 16'(int'($urandom_range(100)) - 20);
      sample_current[31:16] = 16'(int'($urandom_range(100)) - 20);
      if ($urandom_range(15) == 0) i_set = 16'($urandom_range(200));
    end
  endtask

  initial begin
    bit ok;
    int gap;
    chk("model_q_bal", model_q(25, 50), 33);
    chk("model_q_e1", model_q(24, 50), 36);
    chk("model_q_e10", model_q(15, 50), 66);
    chk("model_q_sat", model_q(0, 100), 198);
    chk("model_ton_sat", ton_of(model_q(0, 100)), 180);
    chk("model_q_neg", model_q(40, 50), 16);
    chk("model_q_negid", model_q(-7, 50), 115);

    repeat (3) @(negedge clk);
    chk("reset_overrun", overrun, 0);
    chk("reset_ton", ton, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    en2 = 1'b1;

    run_case(25, 25, 50, 33, 33, 0, 0);
    run_case(24, 15, 50, 36, 66, 0, 0);
    run_case(0, 0, 100, 180, 180, 1, 1);
    run_case(40, -7, 50, 16, 115, 0, 0);

    wait_ps(0, ok);
    chk("ps0_timeout", ok, 1);
    gap = 0;
    for (int i = 0; i < 1000 && !phase_start[1]; i++) begin
      @(negedge clk);
      gap++;
    end
    chk("ps0_to_ps1", gap, SLOT);
    gap = 0;
    for (int i = 0; i < 1000 && !phase_start[0]; i++) begin
      @(negedge clk);
      gap++;
    end
    chk("ps1_to_ps0", gap, CLKT - SLOT);

    run_random(3000);

    wait_ps(0, ok);
    chk("abort_en_timeout", ok, 1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("en_low_ton", ton, 0);
    chk("en_low_ps", phase_start, 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    run_random(1300);

    wait_ps(1, ok);
    chk("abort_rst_timeout", ok, 1);
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ton", ton, 0);
    chk("rst_overrun_short", overrun_o, 0);
    rst_n = 1'b1;
    run_random(1300);

    chk("overrun_short", overrun_o, 1);
    chk("overrun_main_end", overrun, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
